// File: rtl/alvio_ram_cfg.sv
// Active-list violation RAM with partition/lane gating and a built-in
// sequential clear engine that runs after reset, flush or partition change.
module alvio_ram_cfg #(
    parameter int DEPTH     = 16,
    parameter int INDEX     = 4,
    parameter int WIDTH     = 8,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_PARTS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*INDEX-1:0]  addr_i,
    output logic [NUM_RD*WIDTH-1:0]  data_o,
    input  logic [NUM_RD-1:0]        rdLaneActive_i,
    input  logic [NUM_WR*INDEX-1:0]  addrWr_i,
    input  logic [NUM_WR*WIDTH-1:0]  dataWr_i,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_PARTS-1:0]     partActive_i,
    input  logic                     flush_i,
    output logic                     ready_o
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam int PSIZE = DEPTH / NUM_PARTS;
    localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

    logic [WIDTH-1:0]     ram [DEPTH];
    logic [0:0]           state;
    logic [INDEX-1:0]     clr_idx;
    logic [NUM_PARTS-1:0] part_mask_q;
    logic [DEPTH-1:0]     row_on;
    logic                 reclr;

    // Per-row view of the partition enables, so gating is a single lookup.
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        assign row_on[r] = partActive_i[r / PSIZE];
    end

    assign reclr = flush_i || (partActive_i != part_mask_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_CLEAR;
            clr_idx     <= '0;
            ready_o     <= 1'b0;
            part_mask_q <= '1;
        end else begin
            part_mask_q <= partActive_i;
            if (reclr) begin
                state   <= ST_CLEAR;
                clr_idx <= '0;
                ready_o <= 1'b0;
            end else if (state == ST_CLEAR) begin
                // Explicit compare so non-power-of-two depths terminate.
                if (clr_idx == LAST_IDX) begin
                    state   <= ST_READY;
                    clr_idx <= '0;
                    ready_o <= 1'b1;
                end else begin
                    clr_idx <= clr_idx + 1'b1;
                end
            end
        end
    end

    // Later ports override earlier ones on an address collision.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            ram[clr_idx] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we_i[j] && row_on[addrWr_i[j*INDEX +: INDEX]])
                    ram[addrWr_i[j*INDEX +: INDEX]] <= dataWr_i[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        logic [INDEX-1:0] ra;
        ra     = '0;
        data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = addr_i[k*INDEX +: INDEX];
            if (ready_o && rdLaneActive_i[k] && row_on[ra])
                data_o[k*WIDTH +: WIDTH] = ram[ra];
        end
    end

endmodule

// File: tb/tb_alvio_ram_cfg.sv
// Directed self-checking bench for alvio_ram_cfg (default parameters).
module tb_alvio_ram_cfg;

    logic        clk;
    logic        reset;
    logic [15:0] addr_i;
    logic [31:0] data_o;
    logic [3:0]  rdLaneActive_i;
    logic [7:0]  addrWr_i;
    logic [15:0] dataWr_i;
    logic [1:0]  we_i;
    logic [3:0]  partActive_i;
    logic        flush_i;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    alvio_ram_cfg dut (
        .clk            (clk),
        .reset          (reset),
        .addr_i         (addr_i),
        .data_o         (data_o),
        .rdLaneActive_i (rdLaneActive_i),
        .addrWr_i       (addrWr_i),
        .dataWr_i       (dataWr_i),
        .we_i           (we_i),
        .partActive_i   (partActive_i),
        .flush_i        (flush_i),
        .ready_o        (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until ready_o rises; bounded so a stuck clear cannot hang.
    task automatic wait_rdy(output int cnt);
        cnt = 0;
        while (!ready_o && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    task automatic set_rd(input int k, input logic [3:0] a);
        addr_i[k*4 +: 4] = a;
        #1;
    endtask

    function automatic logic [7:0] lane(input int k);
        return data_o[k*8 +: 8];
    endfunction

    task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d);
        addrWr_i[p*4 +: 4] = a;
        dataWr_i[p*8 +: 8] = d;
        we_i[p]            = 1'b1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        addr_i         = '0;
        rdLaneActive_i = 4'hF;
        addrWr_i       = '0;
        dataWr_i       = '0;
        we_i           = '0;
        partActive_i   = 4'hF;
        flush_i        = 1'b0;

        // 1: reset release and clear latency
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready_o}, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_rdy(n);
        chk("rst_lat", n, 16);
        chk("rst_data", data_o, 0);

        // 2: read-during-write returns the old value
        wr(0, 4'd5, 8'hA5);
        set_rd(2, 4'd5);
        chk("rdw_old", lane(2), 8'h00);
        step();
        we_i = '0;
        #1;
        chk("rdw_new", lane(2), 8'hA5);

        // 3: same-address collision, lane gating
        wr(0, 4'd9, 8'h11);
        wr(1, 4'd9, 8'h22);
        step();
        we_i = '0;
        set_rd(0, 4'd9);
        chk("coll_p1", lane(0), 8'h22);
        set_rd(1, 4'd9);
        chk("lane1_on", lane(1), 8'h22);
        rdLaneActive_i[1] = 1'b0;
        #1;
        chk("lane1_off", lane(1), 8'h00);
        rdLaneActive_i[1] = 1'b1;

        // 4: partition reconfiguration
        partActive_i = 4'b0011;
        step();
        chk("part_drop", {31'b0, ready_o}, 0);
        wait_rdy(n);
        chk("part_lat", n, 16);
        set_rd(0, 4'd5);
        chk("part_clr5", lane(0), 8'h00);
        wr(0, 4'd12, 8'h5A);
        wr(1, 4'd2, 8'h77);
        step();
        we_i = '0;
        set_rd(0, 4'd12);
        chk("part_rd12", lane(0), 8'h00);
        set_rd(1, 4'd2);
        chk("part_rd2", lane(1), 8'h77);
        partActive_i = 4'hF;
        step();
        wait_rdy(n);
        chk("part_re_lat", n, 16);
        #1;
        chk("part_re12", lane(0), 8'h00);
        chk("part_re2", lane(1), 8'h00);

        // 5: flush, then flush restarted at clear cycle 7
        wr(0, 4'd3, 8'hFF);
        step();
        we_i = '0;
        set_rd(3, 4'd3);
        chk("fl_wr3", lane(3), 8'hFF);
        do_flush();
        chk("fl_drop", {31'b0, ready_o}, 0);
        wait_rdy(n);
        chk("fl_lat", n, 16);
        #1;
        chk("fl_clr3", lane(3), 8'h00);
        do_flush();
        repeat (6) step();
        do_flush();
        wait_rdy(n);
        chk("fl2_lat", n + 7, 23);

        // 6: asynchronous reset mid-clear and mid-ready
        do_flush();
        repeat (9) step();
        reset = 1'b0;
        #2;
        chk("arst_clr", {31'b0, ready_o}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_rdy(n);
        chk("arst_clr_lat", n, 16);
        wr(1, 4'd7, 8'h3C);
        step();
        we_i = '0;
        set_rd(2, 4'd7);
        chk("arst_wr7", lane(2), 8'h3C);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_rdy", {31'b0, ready_o}, 0);
        chk("arst_gate", lane(2), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        wait_rdy(n);
        chk("arst_rdy_lat", n, 16);
        #1;
        chk("arst_clr7", lane(2), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
